seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Parametrised multiplexed seven-segment driver: time-multiplexes NUM_DIGITS hex digits onto one shared, active-low segment bus. Adds decimal points, per-digit blanking and blinking, an anti-ghosting guard interval, and a load-strobed shadow register so a display frame never shows a mix of old and new values. It sits between the game/score logic and the board's segment/anode pins, replacing the fixed 4-digit scanner.

## Interface
- NUM_DIGITS, 4: digits scanned, ≥2.
- SCAN_CYCLES, 50000: clk cycles per digit slot, ≥4.
- GUARD_CYCLES, 500: dark cycles at the start of each slot, must be < SCAN_CYCLES.
- BLINK_FRAMES, 64: full scan frames per blink half-period, ≥1.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  shadow capture strobe, one cycle wide.
- nums  in  4*NUM_DIGITS  hex nibbles; digit i is nums[4i+3:4i], and digit 0 is the rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
- blank  in  NUM_DIGITS  force digit dark, active-high.
- blink  in  NUM_DIGITS  digit blinks, active-high.
- display  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- digit  out  NUM_DIGITS  anode select, one-cold or all-ones, registered.

## Operation
- Shadow registers hold sh_nums, sh_dp, sh_blank and sh_blink.
  - On a clk edge with load=1, all four capture their inputs together.
  - Decode uses shadow values only.
  - load=1 held for several cycles recaptures on every cycle.
- Prescaler `pre` counts 0..SCAN_CYCLES-1 and wraps.
  - At the wrap, `idx` advances: 0→1→…→NUM_DIGITS-1→0.
- Frame counter counts completed wraps of `idx` from NUM_DIGITS-1 to 0.
  - After BLINK_FRAMES frames it resets to 0 and toggles `phase`.
- Digit `idx` is dark when any of these holds:
  - pre < GUARD_CYCLES;
  - sh_blank[idx];
  - sh_blink[idx] and phase=1.
- Dark: digit = all ones, display = 7'h7F, dp = 1.
- Otherwise:
  - digit = ~(1 << idx);
  - display = hex decode of sh_nums[idx] (0-F; A,b,C,d,E,F glyphs);
  - dp = ~sh_dp[idx].
- Blank has priority over blink. The guard interval overrides everything.

## Timing
- Reset values:
  - pre=0, idx=0, frame=0, phase=0;
  - all shadows 0;
  - display=7'h7F, dp=1, digit=all ones.
- Outputs are registered from the current pre/idx/shadow state, so each output lags that state by 1 cycle.
- load → visible: a capture at edge k shows on the outputs at edge k+1, provided the slot is not dark.
- A load during the active part of a slot changes the current digit mid-slot. No deferral is applied; the guard applies only at slot start.
- Reset asserted mid-slot forces the outputs dark immediately (asynchronous). After release, scanning restarts at idx 0 with the guard interval.
- Full frame period = NUM_DIGITS × SCAN_CYCLES cycles.
- Blink period = 2 × BLINK_FRAMES frames.
- Counter widths use $clog2 of the respective bound, with a minimum of 1.

## Structure
- Package seg7_pkg holds:
  - function hex_to_seg(logic [3:0]) → logic [6:0] (active-low);
  - constant SEG_OFF = 7'h7F.
- Sub-module scan_timer instance generates pre, idx, frame and phase, plus a slot_start pulse. It has the same clk/rst_n ports.
- The top level holds the shadow registers, the select/decode mux, and the output registers.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, SCAN_CYCLES=8, GUARD_CYCLES=2, BLINK_FRAMES=2.
- **Reset:** rst_n=0 → display=7F, dp=1, digit=4'b1111. Release, load nums=16'h1234 → in slot 0 active cycles, digit=1110 and display=hex_to_seg(4).
- **Scan order and guard:** after load, for 64 cycles → per 8-cycle slot, 2 dark cycles, then 6 cycles of digit=1110/1101/1011/0111 showing 4,3,2,1.
- **Shadow isolation:** change nums to 16'hABCD with load=0 → display keeps 1234 glyphs. Pulse load → next active cycle shows D on the current digit.
- **Blank and dp:** blank=4'b0010, dp_in=4'b0001, load → slot 1 stays all ones for 8 cycles. Slot 0 has dp=0, other slots dp=1.
- **Blink:** blink=4'b1000, load → digit 3 is lit for 2 frames (64 cycles), dark for 2 frames, then lit again. Additionally setting blank[3] → dark in both phases.
- **Async reset mid-slot:** assert rst_n=0 at pre=5, idx=2 → outputs dark in the same cycle. After release, the first lit digit is 1110, at cycle 3 after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types, constants and helpers for the multiplexed seven-segment scanner.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef struct packed {
    logic [6:0] display;
    logic       dp;
  } seg_out_t;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side load/data bus and pin-side segment/anode outputs of the scanner.
interface seg7_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] nums;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   blink;
  logic [6:0]              display;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   digit;

  modport master (
    output load, nums, dp_in, blank, blink,
    input  display, dp, digit
  );

  modport slave (
    input  load, nums, dp_in, blank, blink,
    output display, dp, digit
  );
endinterface

// File: rtl/scan_timer.sv
// Slot prescaler, digit index, frame counter and blink phase for the scanner.
module scan_timer
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_CYCLES  = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  localparam int unsigned PRE_W = cnt_width(SCAN_CYCLES),
  localparam int unsigned IDX_W = cnt_width(NUM_DIGITS),
  localparam int unsigned FRM_W = cnt_width(BLINK_FRAMES)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [PRE_W-1:0] pre,
  output logic [IDX_W-1:0] idx,
  output logic [FRM_W-1:0] frame,
  output logic             phase,
  output logic             slot_start
);

  logic wrap_c;
  logic last_idx_c;
  logic last_frame_c;

  assign wrap_c       = (pre == PRE_W'(SCAN_CYCLES - 1));
  assign last_idx_c   = (idx == IDX_W'(NUM_DIGITS - 1));
  assign last_frame_c = (frame == FRM_W'(BLINK_FRAMES - 1));

  // A frame completes when the last digit's slot wraps back to digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      idx        <= '0;
      frame      <= '0;
      phase      <= 1'b0;
      slot_start <= 1'b1;
    end else begin
      slot_start <= wrap_c;
      if (wrap_c) begin
        pre <= '0;
        if (last_idx_c) begin
          idx <= '0;
          if (last_frame_c) begin
            frame <= '0;
            phase <= ~phase;
          end else begin
            frame <= frame + FRM_W'(1);
          end
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment driver: shadowed digit data, blank/blink/dp and guard-gated scan.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_CYCLES  = 50000,
  parameter int unsigned GUARD_CYCLES = 500,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int unsigned PRE_W = cnt_width(SCAN_CYCLES);
  localparam int unsigned IDX_W = cnt_width(NUM_DIGITS);
  localparam int unsigned FRM_W = cnt_width(BLINK_FRAMES);

  logic [PRE_W-1:0] pre;
  logic [IDX_W-1:0] idx;
  logic [FRM_W-1:0] frame;
  logic             phase;
  logic             slot_start;

  logic [NUM_DIGITS-1:0][3:0] sh_nums;
  logic [NUM_DIGITS-1:0]      sh_dp;
  logic [NUM_DIGITS-1:0]      sh_blank;
  logic [NUM_DIGITS-1:0]      sh_blink;

  seg_out_t              out_d;
  seg_out_t              out_q;
  logic [NUM_DIGITS-1:0] digit_d;
  logic [NUM_DIGITS-1:0] digit_q;
  logic                  dark_c;

  // Frame count and slot-start pulse are not needed by the output path.
  logic unused_timer;
  assign unused_timer = ^{frame, slot_start};

  scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .SCAN_CYCLES  (SCAN_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_scan_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .pre        (pre),
    .idx        (idx),
    .frame      (frame),
    .phase      (phase),
    .slot_start (slot_start)
  );

  // Shadow copy taken on load so a frame never mixes old and new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_nums  <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      sh_blink <= '0;
    end else if (bus.load) begin
      sh_nums  <= bus.nums;
      sh_dp    <= bus.dp_in;
      sh_blank <= bus.blank;
      sh_blink <= bus.blink;
    end
  end

  // Guard interval first, then blank, then blink-off phase darken the slot.
  always_comb begin
    out_d   = '{display: SEG_OFF, dp: 1'b1};
    digit_d = '1;
    dark_c  = (pre < PRE_W'(GUARD_CYCLES)) || sh_blank[idx] || (sh_blink[idx] && phase);
    if (!dark_c) begin
      out_d.display = hex_to_seg(sh_nums[idx]);
      out_d.dp      = ~sh_dp[idx];
      digit_d       = ~(NUM_DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '{display: SEG_OFF, dp: 1'b1};
      digit_q <= '1;
    end else begin
      out_q   <= out_d;
      digit_q <= digit_d;
    end
  end

  assign bus.display = out_q.display;
  assign bus.dp      = out_q.dp;
  assign bus.digit   = digit_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed, table-driven bench for seg7_scan_ctrl with a small 4-digit scan.
module tb_seg7_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 8;
  localparam int unsigned GC = 2;
  localparam int unsigned BF = 2;
  localparam logic [11:0] DARK = 12'hFFF;

  typedef struct {
    logic [15:0] nums;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [3:0]  blink;
    int          slot;
    logic [11:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n = 0;
  int   compared = 0;
  int   mismatched = 0;

  vec_t        vecs[18];
  logic [11:0] slot_tab[4];

  seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_CYCLES  (SC),
    .GUARD_CYCLES (GC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [11:0] lit(input logic [3:0] dg, input logic [6:0] seg, input logic dpv);
    return {dg, seg, dpv};
  endfunction

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = {bus.digit, bus.display, bus.dp};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got digit=%b display=%h dp=%b expected digit=%b display=%h dp=%b",
               name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic load_cfg(input logic [15:0] nv, input logic [3:0] dv,
                          input logic [3:0] bl, input logic [3:0] bk);
    bus.nums  = nv;
    bus.dp_in = dv;
    bus.blank = bl;
    bus.blink = bk;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
  endtask

  // Step until the timer state after the latest edge is (slot, pre_v).
  task automatic wait_state(input int slot, input int pre_v, input string name);
    int steps;
    steps = 0;
    do begin
      step();
      steps++;
    end while (!((n % SC == pre_v) && ((n / SC) % ND == slot)) && steps < 40);
    if (!((n % SC == pre_v) && ((n / SC) % ND == slot))) begin
      compared++;
      mismatched++;
      $display("FAIL %s: got no slot %0d pre %0d within 40 cycles expected reached", name, slot, pre_v);
    end
  endtask

  initial begin
    int m;
    slot_tab[0] = lit(4'b1110, 7'h19, 1'b1);
    slot_tab[1] = lit(4'b1101, 7'h30, 1'b1);
    slot_tab[2] = lit(4'b1011, 7'h24, 1'b1);
    slot_tab[3] = lit(4'b0111, 7'h79, 1'b1);

    vecs[0]  = '{16'h1234, 4'b0000, 4'b0000, 4'b0000, 0, lit(4'b1110, 7'h19, 1'b1)};
    vecs[1]  = '{16'h1234, 4'b0000, 4'b0000, 4'b0000, 3, lit(4'b0111, 7'h79, 1'b1)};
    vecs[2]  = '{16'hABCD, 4'b0000, 4'b0000, 4'b0000, 0, lit(4'b1110, 7'h21, 1'b1)};
    vecs[3]  = '{16'hABCD, 4'b0000, 4'b0000, 4'b0000, 1, lit(4'b1101, 7'h46, 1'b1)};
    vecs[4]  = '{16'hABCD, 4'b0000, 4'b0000, 4'b0000, 2, lit(4'b1011, 7'h03, 1'b1)};
    vecs[5]  = '{16'hABCD, 4'b0000, 4'b0000, 4'b0000, 3, lit(4'b0111, 7'h08, 1'b1)};
    vecs[6]  = '{16'h5678, 4'b0001, 4'b0010, 4'b0000, 1, DARK};
    vecs[7]  = '{16'h5678, 4'b0001, 4'b0010, 4'b0000, 0, lit(4'b1110, 7'h00, 1'b0)};
    vecs[8]  = '{16'h5678, 4'b0001, 4'b0010, 4'b0000, 2, lit(4'b1011, 7'h02, 1'b1)};
    vecs[9]  = '{16'h09EF, 4'b0000, 4'b0000, 4'b0000, 0, lit(4'b1110, 7'h0E, 1'b1)};
    vecs[10] = '{16'h09EF, 4'b0000, 4'b0000, 4'b0000, 1, lit(4'b1101, 7'h06, 1'b1)};
    vecs[11] = '{16'h09EF, 4'b0000, 4'b0000, 4'b0000, 2, lit(4'b1011, 7'h10, 1'b1)};
    vecs[12] = '{16'h09EF, 4'b0000, 4'b0000, 4'b0000, 3, lit(4'b0111, 7'h40, 1'b1)};
    vecs[13] = '{16'h0057, 4'b0000, 4'b0000, 4'b0000, 0, lit(4'b1110, 7'h78, 1'b1)};
    vecs[14] = '{16'h0057, 4'b0000, 4'b0000, 4'b0000, 1, lit(4'b1101, 7'h12, 1'b1)};
    vecs[15] = '{16'h1234, 4'b0000, 4'b1111, 4'b0000, 2, DARK};
    vecs[16] = '{16'h1234, 4'b0000, 4'b0100, 4'b0100, 2, DARK};
    vecs[17] = '{16'h1234, 4'b1111, 4'b0000, 4'b0000, 3, lit(4'b0111, 7'h79, 1'b0)};

    bus.load  = 1'b0;
    bus.nums  = '0;
    bus.dp_in = '0;
    bus.blank = '0;
    bus.blink = '0;

    // Reset holds the outputs dark.
    repeat (3) @(posedge clk);
    #1;
    check("reset_dark", DARK);

    // Release, load 1234, then scan 64 cycles with guard intervals.
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    load_cfg(16'h1234, 4'b0000, 4'b0000, 4'b0000);
    check("first_cycle_dark", DARK);
    for (int i = 0; i < 64; i++) begin
      step();
      m = n - 1;
      check($sformatf("scan_m%0d", m), (m % SC < GC) ? DARK : slot_tab[(m / SC) % ND]);
    end

    // New data without load must not reach the display.
    bus.nums = 16'hABCD;
    for (int i = 0; i < 16; i++) begin
      step();
      m = n - 1;
      check($sformatf("shadow_hold_m%0d", m), (m % SC < GC) ? DARK : slot_tab[(m / SC) % ND]);
    end

    // Load mid-slot on digit 0 switches the glyph on the next cycle.
    wait_state(0, 3, "iso_align");
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check("iso_before", lit(4'b1110, 7'h19, 1'b1));
    step();
    check("iso_after", lit(4'b1110, 7'h21, 1'b1));

    // Table of configurations, each probed mid-slot on one digit.
    for (int i = 0; i < 18; i++) begin
      load_cfg(vecs[i].nums, vecs[i].dp_in, vecs[i].blank, vecs[i].blink);
      wait_state(vecs[i].slot, 5, $sformatf("vec%0d_align", i));
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Blinking digit 3 alternates lit/dark every two frames.
    load_cfg(16'h1234, 4'b0000, 4'b0000, 4'b1000);
    for (int i = 0; i < 256; i++) begin
      step();
      m = n - 1;
      if ((m % SC == 4) && ((m / SC) % ND == 3))
        check($sformatf("blink_m%0d", m), (((m / 64) % 2) == 0) ? lit(4'b0111, 7'h79, 1'b1) : DARK);
    end

    // Blank overrides blink in both phases.
    load_cfg(16'h1234, 4'b0000, 4'b1000, 4'b1000);
    for (int i = 0; i < 128; i++) begin
      step();
      m = n - 1;
      if ((m % SC == 4) && ((m / SC) % ND == 3))
        check($sformatf("blink_blank_m%0d", m), DARK);
    end

    // Asynchronous reset at pre=5, idx=2, then restart from digit 0.
    load_cfg(16'h1234, 4'b0000, 4'b0000, 4'b0000);
    wait_state(2, 5, "areset_align");
    check("areset_before", lit(4'b1011, 7'h24, 1'b1));
    rst_n = 1'b0;
    #1;
    check("areset_dark", DARK);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    step();
    check("areset_rel1", DARK);
    step();
    check("areset_rel2", DARK);
    step();
    check("areset_rel3", lit(4'b1110, 7'h40, 1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
